// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the pipelined add/subtract datapath.
package pipe_addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // True when the operand width splits evenly into the requested slice count.
  function automatic bit divides(input int unsigned width, input int unsigned parts);
    return (parts != 0) && ((width % parts) == 0);
  endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
interface pipe_addsub_if #(
  parameter int unsigned bits = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [bits-1:0] x;
  logic [bits-1:0] y;
  logic            mode;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [bits-1:0] sum;
  logic            cout;
  logic            ovf;
  logic            zero;

  modport master (
    output in_valid, x, y, mode, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, x, y, mode, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipe_addsub_slice.sv
// Combinational W-bit ripple add/subtract slice.
module addsub_slice
  import pipe_addsub_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         mode,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] c;
  logic       ty;

  // Bitwise ripple: operand B is inverted in subtract mode, carry chained upward.
  always_comb begin
    sum  = '0;
    c    = '0;
    ty   = 1'b0;
    c[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      ty       = y[i] ^ (mode == MODE_SUB);
      sum[i]   = x[i] ^ ty ^ c[i];
      c[i+1]   = (x[i] & ty) | (x[i] & c[i]) | (ty & c[i]);
    end
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: bits split into stages carry-chained slices,
// one register rank per slice, global-stall valid/ready handshake.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int unsigned bits   = 32,
  parameter int unsigned stages = 4
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave bus
);

  localparam int unsigned W = bits / stages;

  if (!divides(bits, stages)) begin : g_bad_cfg
    $fatal(1, "pipe_addsub: bits must be a non-zero multiple of stages");
  end

  logic adv;

  // Every rank moves together; a full output that is not taken stalls the pipe.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < stages; k++) begin : g_st
    // Bits below LO have already been summed by earlier ranks.
    localparam int unsigned LO = k * W;

    logic [W-1:0]      sl_x;
    logic [W-1:0]      sl_y;
    logic              sl_mode;
    logic              sl_cin;
    logic              sl_v;
    logic [W-1:0]      sl_sum;
    logic              sl_cout;
    logic              sl_cmsb;
    logic [LO+W-1:0]   s_d;
    logic [LO+W-1:0]   s_q;
    logic              v_q;
    logic              c_q;

    // Slice operands come straight from the bus for rank 0, else from the
    // skewed operand bits held by the previous rank.
    if (k == 0) begin : g_src
      assign sl_x    = bus.x[W-1:0];
      assign sl_y    = bus.y[W-1:0];
      assign sl_mode = bus.mode;
      assign sl_cin  = bus.cin;
      assign sl_v    = bus.in_valid;
      assign s_d     = sl_sum;
    end else begin : g_src
      assign sl_x    = g_st[k-1].g_fwd.xr_q[W-1:0];
      assign sl_y    = g_st[k-1].g_fwd.yr_q[W-1:0];
      assign sl_mode = g_st[k-1].g_fwd.mode_q;
      assign sl_cin  = g_st[k-1].c_q;
      assign sl_v    = g_st[k-1].v_q;
      assign s_d     = {sl_sum, g_st[k-1].s_q};
    end

    addsub_slice #(.W(W)) u_slice (
      .x        (sl_x),
      .y        (sl_y),
      .mode     (sl_mode),
      .cin      (sl_cin),
      .sum      (sl_sum),
      .cout     (sl_cout),
      .c_msb_in (sl_cmsb)
    );

    // Rank register: valid, slice carry-out and accumulated low sum bits.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= sl_v;
        c_q <= sl_cout;
        s_q <= s_d;
      end
    end

    if (k < stages - 1) begin : g_fwd
      // Operand bits not yet consumed travel alongside the partial sum.
      localparam int unsigned REM = bits - LO - W;

      logic [REM-1:0] xr_d;
      logic [REM-1:0] yr_d;
      logic [REM-1:0] xr_q;
      logic [REM-1:0] yr_q;
      logic           mode_q;

      if (k == 0) begin : g_skew
        assign xr_d = bus.x[bits-1:W];
        assign yr_d = bus.y[bits-1:W];
      end else begin : g_skew
        assign xr_d = g_st[k-1].g_fwd.xr_q[REM+W-1:W];
        assign yr_d = g_st[k-1].g_fwd.yr_q[REM+W-1:W];
      end

      // Skewed operand register for the remaining upper slices.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          xr_q   <= '0;
          yr_q   <= '0;
          mode_q <= 1'b0;
        end else if (adv) begin
          xr_q   <= xr_d;
          yr_q   <= yr_d;
          mode_q <= sl_mode;
        end
      end
    end else begin : g_out
      logic ovf_q;
      logic zero_q;

      // Flags of the completed sum, registered with the final rank.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= sl_cmsb ^ sl_cout;
          zero_q <= (s_d == '0);
        end
      end

      assign bus.out_valid = v_q;
      assign bus.sum       = s_q;
      assign bus.cout      = c_q;
      assign bus.ovf       = ovf_q;
      assign bus.zero      = zero_q;
    end
  end

endmodule
